// File: rtl/score_keeper.sv
// Score, line and level accumulator for the game display path.
// Each accepted line-clear event updates the counters, then a double-dabble pass refreshes the BCD digits.
module score_keeper #(
  parameter int SCORE_W         = 14,
  parameter int MAX_SCORE       = 999,
  parameter int PTS1            = 1,
  parameter int PTS2            = 3,
  parameter int PTS3            = 5,
  parameter int PTS4            = 8,
  parameter int LINES_PER_LEVEL = 10,
  parameter int MAX_LEVEL       = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_valid,
  input  logic [2:0]         clear_lines,
  output logic               clear_ready,
  input  logic               game_over,
  input  logic               new_game,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         level,
  output logic [9:0]         lines_total,
  output logic [SCORE_W-1:0] hi_score,
  output logic [3:0]         dig2,
  output logic [3:0]         dig1,
  output logic [3:0]         dig0,
  output logic               bcd_valid,
  output logic [2:0]         state_dbg
);

  // Handshake: an event transfers on a rising clk edge where clear_valid && clear_ready;
  // clear_lines is sampled on that edge only, and clear_ready is high only while IDLE and not game_over.

  localparam int SUM_W   = SCORE_W + 1;
  localparam int BCD_W   = 12;
  localparam int SR_W    = BCD_W + SCORE_W;
  localparam int ITER_W  = $clog2(SCORE_W + 1);
  localparam int LCNT_W  = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADD  = 3'd1,
    LVL  = 3'd2,
    CONV = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          lines_cap_q, lines_cap_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [SCORE_W-1:0]  hi_q, hi_d;
  logic [3:0]          level_q, level_d;
  logic [9:0]          lines_total_q, lines_total_d;
  logic [LCNT_W-1:0]   inlvl_q, inlvl_d;
  logic [SR_W-1:0]     sreg_q, sreg_d;
  logic [ITER_W-1:0]   iter_q, iter_d;
  logic [3:0]          dig2_q, dig2_d;
  logic [3:0]          dig1_q, dig1_d;
  logic [3:0]          dig0_q, dig0_d;
  logic                bcd_valid_q, bcd_valid_d;

  logic                accept;
  logic                lines_ok;
  logic [7:0]          pts;
  logic [7:0]          mult;
  logic [SUM_W-1:0]    score_sum;
  logic [10:0]         lines_sum;
  logic [LCNT_W-1:0]   inlvl_sum;
  logic [BCD_W-1:0]    bcd_adj;
  logic [SR_W-1:0]     dd_next;

  assign clear_ready = (state_q == IDLE) && !game_over;
  assign accept      = clear_valid && clear_ready;
  assign lines_ok    = (clear_lines >= 3'd1) && (clear_lines <= 3'd4);

  always_comb begin
    case (lines_cap_q)
      3'd1:    pts = 8'(PTS1);
      3'd2:    pts = 8'(PTS2);
      3'd3:    pts = 8'(PTS3);
      3'd4:    pts = 8'(PTS4);
      default: pts = 8'd0;
    endcase
  end

  // Widened sum so the saturation compare sees the true total before any wrap.
  assign mult      = pts * (8'(level_q) + 8'd1);
  assign score_sum = {1'b0, score_q} + SUM_W'(mult);
  assign lines_sum = {1'b0, lines_total_q} + 11'(lines_cap_q);
  assign inlvl_sum = inlvl_q + LCNT_W'(lines_cap_q);

  // One double-dabble step: correct each BCD nibble, then shift the whole register left.
  always_comb begin
    bcd_adj = sreg_q[SR_W-1 -: BCD_W];
    for (int i = 0; i < 3; i++) begin
      if (bcd_adj[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_adj[i*4 +: 4] + 4'd3;
      end
    end
    dd_next = {bcd_adj, sreg_q[SCORE_W-1:0]} << 1;
  end

  always_comb begin
    state_d       = state_q;
    lines_cap_d   = lines_cap_q;
    score_d       = score_q;
    hi_d          = hi_q;
    level_d       = level_q;
    lines_total_d = lines_total_q;
    inlvl_d       = inlvl_q;
    sreg_d        = sreg_q;
    iter_d        = iter_q;
    dig2_d        = dig2_q;
    dig1_d        = dig1_q;
    dig0_d        = dig0_q;
    bcd_valid_d   = 1'b0;

    if (new_game) begin
      state_d       = IDLE;
      score_d       = '0;
      level_d       = '0;
      lines_total_d = '0;
      inlvl_d       = '0;
      iter_d        = '0;
      dig2_d        = '0;
      dig1_d        = '0;
      dig0_d        = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            lines_cap_d = clear_lines;
            if (lines_ok) state_d = ADD;
          end
        end
        ADD: begin
          if (score_sum > SUM_W'(MAX_SCORE)) score_d = SCORE_W'(MAX_SCORE);
          else                               score_d = score_sum[SCORE_W-1:0];
          state_d = LVL;
        end
        LVL: begin
          if (lines_sum > 11'd999) lines_total_d = 10'd999;
          else                     lines_total_d = lines_sum[9:0];
          // The in-level counter wraps even once the level has hit its ceiling.
          if (inlvl_sum >= LCNT_W'(LINES_PER_LEVEL)) begin
            inlvl_d = inlvl_sum - LCNT_W'(LINES_PER_LEVEL);
            if (level_q < 4'(MAX_LEVEL)) level_d = level_q + 4'd1;
          end else begin
            inlvl_d = inlvl_sum;
          end
          sreg_d  = {{BCD_W{1'b0}}, score_q};
          iter_d  = '0;
          state_d = CONV;
        end
        CONV: begin
          sreg_d = dd_next;
          iter_d = iter_q + 1'b1;
          if (iter_q == ITER_W'(SCORE_W - 1)) state_d = DONE;
        end
        DONE: begin
          dig2_d      = sreg_q[SR_W-1 -: 4];
          dig1_d      = sreg_q[SR_W-5 -: 4];
          dig0_d      = sreg_q[SR_W-9 -: 4];
          bcd_valid_d = 1'b1;
          if (score_q > hi_q) hi_d = score_q;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      lines_cap_q   <= '0;
      score_q       <= '0;
      hi_q          <= '0;
      level_q       <= '0;
      lines_total_q <= '0;
      inlvl_q       <= '0;
      sreg_q        <= '0;
      iter_q        <= '0;
      dig2_q        <= '0;
      dig1_q        <= '0;
      dig0_q        <= '0;
      bcd_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      lines_cap_q   <= lines_cap_d;
      score_q       <= score_d;
      hi_q          <= hi_d;
      level_q       <= level_d;
      lines_total_q <= lines_total_d;
      inlvl_q       <= inlvl_d;
      sreg_q        <= sreg_d;
      iter_q        <= iter_d;
      dig2_q        <= dig2_d;
      dig1_q        <= dig1_d;
      dig0_q        <= dig0_d;
      bcd_valid_q   <= bcd_valid_d;
    end
  end

  assign score       = score_q;
  assign hi_score    = hi_q;
  assign level       = level_q;
  assign lines_total = lines_total_q;
  assign dig2        = dig2_q;
  assign dig1        = dig1_q;
  assign dig0        = dig0_q;
  assign bcd_valid   = bcd_valid_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: scenario tasks with a reference model and a digit scoreboard.
module tb_score_keeper;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_valid;
  logic [2:0]  clear_lines;
  logic        clear_ready;
  logic        game_over;
  logic        new_game;
  logic [13:0] score;
  logic [3:0]  level;
  logic [9:0]  lines_total;
  logic [13:0] hi_score;
  logic [3:0]  dig2, dig1, dig0;
  logic        bcd_valid;
  logic [2:0]  state_dbg;

  int errors = 0;
  int checks = 0;

  logic [11:0] exp_q[$];

  int m_score, m_level, m_lines, m_inlvl, m_hi;

  always #5 clk = ~clk;

  score_keeper dut (
    .clk         (clk),
    .rst         (rst),
    .clear_valid (clear_valid),
    .clear_lines (clear_lines),
    .clear_ready (clear_ready),
    .game_over   (game_over),
    .new_game    (new_game),
    .score       (score),
    .level       (level),
    .lines_total (lines_total),
    .hi_score    (hi_score),
    .dig2        (dig2),
    .dig1        (dig1),
    .dig0        (dig0),
    .bcd_valid   (bcd_valid),
    .state_dbg   (state_dbg)
  );

  // Scoreboard: every bcd_valid pulse must match the oldest expected digit triple.
  always @(negedge clk) begin
    if (rst === 1'b1 && bcd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL bcd_unexpected got=%h%h%h required=no_pulse t=%0t", dig2, dig1, dig0, $time);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        if ({dig2, dig1, dig0} !== e) begin
          errors++;
          $display("FAIL bcd_digits got=%h%h%h required=%h t=%0t", dig2, dig1, dig0, e, $time);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_clear(input bit keep_hi);
    m_score = 0; m_level = 0; m_lines = 0; m_inlvl = 0;
    if (!keep_hi) m_hi = 0;
  endtask

  task automatic model_event(input int n);
    int pts;
    pts = (n == 1) ? 1 : (n == 2) ? 3 : (n == 3) ? 5 : 8;
    m_score = m_score + pts * (m_level + 1);
    if (m_score > 999) m_score = 999;
    m_lines = m_lines + n;
    if (m_lines > 999) m_lines = 999;
    m_inlvl = m_inlvl + n;
    if (m_inlvl >= 10) begin
      m_inlvl = m_inlvl - 10;
      if (m_level < 9) m_level++;
    end
    if (m_score > m_hi) m_hi = m_score;
    exp_q.push_back({4'(m_score / 100), 4'((m_score / 10) % 10), 4'(m_score % 10)});
  endtask

  // Present one event at a negedge where clear_ready is high; returns at the negedge after E0.
  task automatic send(input int n, input bit push);
    clear_valid = 1'b1;
    clear_lines = 3'(n);
    tick();
    clear_valid = 1'b0;
    clear_lines = 3'($urandom_range(0, 7));
    if (push && n >= 1 && n <= 4) model_event(n);
  endtask

  task automatic wait_done();
    int i;
    i = 0;
    while (state_dbg !== 3'd0 && i < 40) begin
      tick();
      i++;
    end
    checks++;
    if (state_dbg !== 3'd0) begin
      errors++;
      $display("FAIL wait_idle_timeout got_state=%0d required=0", state_dbg);
    end
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    model_clear(1'b1);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    model_clear(1'b0);
    checks++;
    if (score !== 14'd0 || level !== 4'd0 || lines_total !== 10'd0) begin
      errors++;
      $display("FAIL reset_counters got=%0d/%0d/%0d required=0/0/0", score, level, lines_total);
    end
    checks++;
    if (hi_score !== 14'd0 || {dig2, dig1, dig0} !== 12'h000) begin
      errors++;
      $display("FAIL reset_hi_digits got=%0d/%h%h%h required=0/000", hi_score, dig2, dig1, dig0);
    end
    checks++;
    if (bcd_valid !== 1'b0 || clear_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_flags got=valid%b ready%b required=valid0 ready1", bcd_valid, clear_ready);
    end
  endtask

  task automatic test_single();
    send(4, 1'b1);
    checks++;
    if (clear_ready !== 1'b0 || score !== 14'd0) begin
      errors++;
      $display("FAIL single_e0 got=ready%b score%0d required=ready0 score0", clear_ready, score);
    end
    tick();
    checks++;
    if (score !== 14'd8) begin
      errors++;
      $display("FAIL single_e1_score got=%0d required=8", score);
    end
    tick();
    checks++;
    if (lines_total !== 10'd4 || level !== 4'd0) begin
      errors++;
      $display("FAIL single_e2_lines got=%0d lvl%0d required=4 lvl0", lines_total, level);
    end
    for (int i = 3; i <= 16; i++) begin
      tick();
      checks++;
      if (clear_ready !== 1'b0 || bcd_valid !== 1'b0 || {dig2, dig1, dig0} !== 12'h000) begin
        errors++;
        $display("FAIL single_busy_e%0d got=ready%b valid%b dig%h%h%h required=ready0 valid0 dig000",
                 i, clear_ready, bcd_valid, dig2, dig1, dig0);
      end
    end
    tick();
    checks++;
    if (bcd_valid !== 1'b1 || hi_score !== 14'd8 || clear_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_e17 got=valid%b hi%0d ready%b required=valid1 hi8 ready1",
               bcd_valid, hi_score, clear_ready);
    end
    tick();
    checks++;
    if (bcd_valid !== 1'b0 || {dig2, dig1, dig0} !== 12'h008) begin
      errors++;
      $display("FAIL single_hold got=valid%b dig%h%h%h required=valid0 dig008", bcd_valid, dig2, dig1, dig0);
    end
  endtask

  task automatic test_level();
    pulse_new_game();
    for (int k = 0; k < 3; k++) begin
      send(4, 1'b1);
      wait_done();
    end
    checks++;
    if (lines_total !== 10'd12 || level !== 4'd1 || score !== 14'd24) begin
      errors++;
      $display("FAIL level_step got=lines%0d lvl%0d score%0d required=lines12 lvl1 score24",
               lines_total, level, score);
    end
    send(2, 1'b1);
    wait_done();
    checks++;
    if (score !== 14'd30 || {dig2, dig1, dig0} !== 12'h030) begin
      errors++;
      $display("FAIL level_points got=score%0d dig%h%h%h required=score30 dig030", score, dig2, dig1, dig0);
    end
  endtask

  task automatic test_new_game_abort();
    pulse_new_game();
    for (int k = 0; k < 4; k++) begin
      send(4, 1'b1);
      wait_done();
    end
    checks++;
    if (score !== 14'd40 || hi_score !== 14'd40) begin
      errors++;
      $display("FAIL ng_setup got=score%0d hi%0d required=score40 hi40", score, hi_score);
    end
    send(3, 1'b0);
    for (int i = 1; i <= 7; i++) tick();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    model_clear(1'b1);
    checks++;
    if (score !== 14'd0 || level !== 4'd0 || lines_total !== 10'd0 || {dig2, dig1, dig0} !== 12'h000) begin
      errors++;
      $display("FAIL ng_clear got=%0d/%0d/%0d dig%h%h%h required=0/0/0 dig000",
               score, level, lines_total, dig2, dig1, dig0);
    end
    checks++;
    if (state_dbg !== 3'd0 || bcd_valid !== 1'b0 || hi_score !== 14'd40) begin
      errors++;
      $display("FAIL ng_state got=st%0d valid%b hi%0d required=st0 valid0 hi40", state_dbg, bcd_valid, hi_score);
    end
    for (int i = 0; i < 20; i++) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    model_clear(1'b0);
    checks++;
    if (hi_score !== 14'd0) begin
      errors++;
      $display("FAIL ng_rst_hi got=%0d required=0", hi_score);
    end
  endtask

  task automatic test_invalid();
    int bad[3] = '{0, 5, 7};
    send(1, 1'b1);
    wait_done();
    for (int k = 0; k < 3; k++) begin
      send(bad[k], 1'b0);
      checks++;
      if (state_dbg !== 3'd0 || clear_ready !== 1'b1) begin
        errors++;
        $display("FAIL invalid_%0d_state got=st%0d ready%b required=st0 ready1", bad[k], state_dbg, clear_ready);
      end
      tick();
      tick();
      checks++;
      if (score !== 14'(m_score) || lines_total !== 10'(m_lines) || level !== 4'(m_level)) begin
        errors++;
        $display("FAIL invalid_%0d_counters got=%0d/%0d/%0d required=%0d/%0d/%0d",
                 bad[k], score, lines_total, level, m_score, m_lines, m_level);
      end
    end
  endtask

  task automatic test_game_over();
    game_over   = 1'b1;
    clear_valid = 1'b1;
    clear_lines = 3'd4;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (clear_ready !== 1'b0 || state_dbg !== 3'd0) begin
        errors++;
        $display("FAIL blocked_ready got=ready%b st%0d required=ready0 st0", clear_ready, state_dbg);
      end
    end
    game_over   = 1'b0;
    clear_valid = 1'b0;
    tick();
    checks++;
    if (state_dbg !== 3'd0 || score !== 14'(m_score)) begin
      errors++;
      $display("FAIL blocked_not_queued got=st%0d score%0d required=st0 score%0d", state_dbg, score, m_score);
    end
    send(3, 1'b1);
    for (int i = 1; i <= 4; i++) tick();
    game_over = 1'b1;
    wait_done();
    checks++;
    if (score !== 14'(m_score) || clear_ready !== 1'b0) begin
      errors++;
      $display("FAIL go_midevent got=score%0d ready%b required=score%0d ready0", score, clear_ready, m_score);
    end
    game_over = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    int n, i;
    pulse_new_game();
    for (int k = 0; k < 5; k++) begin
      n = $urandom_range(1, 4);
      clear_valid = 1'b1;
      clear_lines = 3'(n);
      i = 0;
      while (clear_ready !== 1'b1 && i < 40) begin
        tick();
        i++;
      end
      checks++;
      if (clear_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready_timeout got=ready%b required=ready1", clear_ready);
      end
      tick();
      model_event(n);
    end
    clear_valid = 1'b0;
    wait_done();
    tick();
    checks++;
    if (score !== 14'(m_score) || lines_total !== 10'(m_lines) || level !== 4'(m_level)
        || hi_score !== 14'(m_hi) || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_totals got=%0d/%0d/%0d hi%0d pend%0d required=%0d/%0d/%0d hi%0d pend0",
               score, lines_total, level, hi_score, exp_q.size(), m_score, m_lines, m_level, m_hi);
    end
  endtask

  task automatic test_saturation();
    int extra;
    pulse_new_game();
    extra = 0;
    for (int k = 0; k < 40 && extra < 3; k++) begin
      if (m_score == 999) extra++;
      send(4, 1'b1);
      wait_done();
      checks++;
      if (score !== 14'(m_score) || level !== 4'(m_level) || lines_total !== 10'(m_lines)) begin
        errors++;
        $display("FAIL sat_event%0d got=%0d/%0d/%0d required=%0d/%0d/%0d",
                 k, score, level, lines_total, m_score, m_level, m_lines);
      end
    end
    checks++;
    if (score !== 14'd999 || {dig2, dig1, dig0} !== 12'h999 || level !== 4'd9 || hi_score !== 14'd999) begin
      errors++;
      $display("FAIL sat_final got=score%0d dig%h%h%h lvl%0d hi%0d required=score999 dig999 lvl9 hi999",
               score, dig2, dig1, dig0, level, hi_score);
    end
  endtask

  initial begin
    rst         = 1'b0;
    clear_valid = 1'b0;
    clear_lines = 3'd0;
    game_over   = 1'b0;
    new_game    = 1'b0;
    model_clear(1'b0);
    @(negedge clk);
    test_reset();
    test_single();
    test_level();
    test_new_game_abort();
    test_invalid();
    test_game_over();
    test_back_to_back();
    test_saturation();
    tick();
    tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_bcd_pulses got=%0d pending required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
